// File: rtl/spi_slave_if.sv
// SPI mode-0 target port, oversampled in the refclk domain.
// Received words leave as rx_valid strobes; a one-entry holding register feeds MISO.
module spi_slave_if #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] IDLE_BYTE = WIDTH'(8'hFF)
) (
  input  logic             refclk,
  input  logic             reset,
  input  logic             extlock,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_active,
  output logic             tx_underrun
);

  localparam int unsigned      CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_d;
  logic             sys_rst;
  logic [2:0]       sclk_sync, cs_sync, mosi_sync;
  logic             sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;
  logic [CW-1:0]    bit_cnt, bit_cnt_d;
  logic [WIDTH-2:0] rx_shift, rx_shift_d;
  logic [WIDTH-1:0] rx_word, rx_data_d;
  logic [WIDTH-1:0] tx_shift, tx_shift_d, hold, hold_d;
  logic             tx_ready_d, load_pend, load_pend_d;
  logic             rx_valid_d, underrun_d, active_d, miso_d;
  logic             load, accept;

  // Losing PLL lock is treated exactly like reset.
  assign sys_rst   = reset | ~extlock;

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  // MOSI from the history flop: the value settled just before the SCLK rise.
  assign mosi_s    = mosi_sync[2];
  assign rx_word   = {rx_shift, mosi_s};
  assign accept    = tx_valid & tx_ready;

  // Next-state and datapath decode.
  always_comb begin
    state_d     = state;
    bit_cnt_d   = bit_cnt;
    rx_shift_d  = rx_shift;
    rx_data_d   = rx_data;
    rx_valid_d  = 1'b0;
    tx_shift_d  = tx_shift;
    hold_d      = hold;
    tx_ready_d  = tx_ready;
    load_pend_d = load_pend;
    underrun_d  = 1'b0;
    load        = 1'b0;

    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_d     = SHIFT;
          load        = 1'b1;
          bit_cnt_d   = '0;
          rx_shift_d  = '0;
          load_pend_d = 1'b0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          // Abort: partial RX word and loaded TX word are both dropped.
          state_d     = IDLE;
          bit_cnt_d   = '0;
          rx_shift_d  = '0;
          load_pend_d = 1'b0;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = rx_word[WIDTH-2:0];
            if (bit_cnt == LAST_BIT) begin
              rx_data_d   = rx_word;
              rx_valid_d  = 1'b1;
              bit_cnt_d   = '0;
              load_pend_d = 1'b1;
            end else begin
              bit_cnt_d = CW'(bit_cnt + 1'b1);
            end
          end
          if (sclk_fall) begin
            if (load_pend) begin
              load        = 1'b1;
              load_pend_d = 1'b0;
            end else begin
              tx_shift_d = {tx_shift[WIDTH-2:0], 1'b0};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load sees the holding register as it was before any same-cycle accept.
    if (load) begin
      if (!tx_ready) begin
        tx_shift_d = hold;
        tx_ready_d = 1'b1;
      end else begin
        tx_shift_d = IDLE_BYTE;
        underrun_d = 1'b1;
      end
    end
    if (accept) begin
      hold_d     = tx_data;
      tx_ready_d = 1'b0;
    end

    active_d = (state_d == SHIFT);
    miso_d   = active_d & tx_shift_d[WIDTH-1];
  end

  // State, synchronizers and registered outputs.
  always_ff @(posedge refclk) begin
    if (sys_rst) begin
      state        <= IDLE;
      sclk_sync    <= '0;
      cs_sync      <= '0;
      mosi_sync    <= '0;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      tx_shift     <= '0;
      hold         <= '0;
      tx_ready     <= 1'b1;
      load_pend    <= 1'b0;
      tx_underrun  <= 1'b0;
      frame_active <= 1'b0;
      miso_oe      <= 1'b0;
      miso         <= 1'b0;
    end else begin
      state        <= state_d;
      sclk_sync    <= {sclk_sync[1:0], sclk};
      cs_sync      <= {cs_sync[1:0], cs_n};
      mosi_sync    <= {mosi_sync[1:0], mosi};
      bit_cnt      <= bit_cnt_d;
      rx_shift     <= rx_shift_d;
      rx_data      <= rx_data_d;
      rx_valid     <= rx_valid_d;
      tx_shift     <= tx_shift_d;
      hold         <= hold_d;
      tx_ready     <= tx_ready_d;
      load_pend    <= load_pend_d;
      tx_underrun  <= underrun_d;
      frame_active <= active_d;
      miso_oe      <= active_d;
      miso         <= miso_d;
    end
  end

endmodule
